identifier_regs: RTL and testbench
==================================

# identifier_regs

Parametrised AXI4-Lite identification and status register block. It is the successor of the read-only identifier and sits on the control interconnect of every IP. It exposes build hash, name, and a three-part version. It adds a writable scratch register, a feature/capability word, up to eight live user status words, and an optional 64-bit uptime counter with coherent two-word reads.

## Interface
- NAME, "TEST": ASCII name, space-padded or truncated to 16 characters.
- HASH, 32'h0: build hash, supplied by the build flow.
- MAJOR_VERSION, 16'd1; MINOR_VERSION, 16'd0; PATCH_VERSION, 16'd0.
- NUM_USER, 0: number of user status words, range 0..8.
- ADDR_WIDTH, 8: width of ctrl_awaddr and ctrl_araddr, minimum 7.
- aclk  in  1  single clock, all logic rising-edge.
- aresetn  in  1  asynchronous, active-low reset.
- ctrl_awvalid/ctrl_awready  in/out  1; ctrl_awaddr  in  ADDR_WIDTH.
- ctrl_wvalid/ctrl_wready  in/out  1; ctrl_wdata  in  32; ctrl_wstrb  in  4.
- ctrl_bvalid/ctrl_bready  out/in  1; ctrl_bresp  out  2.
- ctrl_arvalid/ctrl_arready  in/out  1; ctrl_araddr  in  ADDR_WIDTH.
- ctrl_rvalid/ctrl_rready  out/in  1; ctrl_rdata  out  32; ctrl_rresp  out  2.
- user_info  in  max(NUM_USER,1)*32  live status words; word i is at bits [32i+31:32i].

## Operation
- Decode uses addr[ADDR_WIDTH-1:2] only. Byte offset bits are ignored.
- Register map:
  - 0x00 HASH.
  - 0x04..0x10 NAME words 0..3. The first character is in the LSB byte of word 0.
  - 0x14 {MAJOR,MINOR}.
  - 0x18 {PATCH[31:16], NUM_USER[15:8], FEATURES[7:0]}. FEATURES bit0 = uptime present; bits 7:1 = 0.
  - 0x1C SCRATCH, read/write, reset 0.
  - 0x20 UPTIME_LO.
  - 0x24 UPTIME_HI.
  - 0x28+4i USER[i] for i<NUM_USER, sampled when the read is accepted.
- Unmapped read: rdata 0, rresp SLVERR (2'b10).
- Writes:
  - A write to SCRATCH applies wstrb byte-wise and returns OKAY.
  - A write to any other address has no effect and returns SLVERR.
- Uptime:
  - 64-bit counter, +1 per aclk from reset release, wraps from 2^64-1 to 0.
  - A read of UPTIME_LO returns the live low word and, in the same cycle, latches the live high word into a shadow register.
  - A read of UPTIME_HI returns the shadow. The shadow resets to 0.
- Read and write channels are independent and may complete in the same cycle.
- Simultaneous SCRATCH write and SCRATCH read: the read returns the pre-write value.

## Timing
- Reset values: rvalid 0, rdata 0, rresp 0, bvalid 0, bresp 0, SCRATCH 0, uptime 0, shadow 0.
- ctrl_arready = !ctrl_rvalid (combinational).
- Read handshake at edge N: rvalid=1 with data after edge N. rdata/rresp are held stable until rready is seen with rvalid high, then rvalid drops on the next edge.
- Back-to-back reads: maximum one read per two cycles.
- ctrl_awready = ctrl_wready = ctrl_awvalid && ctrl_wvalid && !ctrl_bvalid.
  - AW and W are accepted together in one cycle.
  - A master that presents only one of them waits.
- Write accepted at edge N: SCRATCH is updated and bvalid=1 after edge N. bvalid is held until bready, then drops on the next edge.
- Reset asserted mid-transaction: all valids drop immediately (asynchronously) and the pending transaction is discarded. No response is issued after release.

## Configuration
- IDENTIFIER_UPTIME_EN defined:
  - Uptime counter and shadow are built.
  - FEATURES bit0 = 1.
  - 0x20/0x24 are mapped as above.
- IDENTIFIER_UPTIME_EN undefined:
  - No counter logic.
  - FEATURES bit0 = 0.
  - Reads of 0x20/0x24 return 0 with SLVERR.

## Structure
- Shared package identifier_pkg holds:
  - register offset constants;
  - response codes RESP_OKAY=2'b00 and RESP_SLVERR=2'b10;
  - the FEATURES bit index constant;
  - NAME_CHARS=16.
- Sub-module identifier_uptime: 64-bit counter plus shadow, with a latch_hi input and lo/hi outputs. It is instantiated only under IDENTIFIER_UPTIME_EN.

## Test plan
- Reset, then read 0x00..0x18 with NAME="TEST", MAJOR=2, MINOR=3, PATCH=4, NUM_USER=2, macro on.
  - Required: 0x04=0x54534554, 0x08..0x10=0x20202020, 0x14=0x00020003, 0x18=0x00040201.
  - All responses OKAY.
- Write 0xDEADBEEF to 0x1C with wstrb 4'b1111, then write 0x00000011 with wstrb 4'b0001, then read 0x1C.
  - Required: bresp OKAY both times; read returns 0xDEADBE11.
- Write to 0x00; read 0x7C.
  - Required: bresp SLVERR and HASH unchanged; rdata 0 with rresp SLVERR.
- Force the uptime counter to 0x00000000_FFFFFFFF just before a UPTIME_LO read, then read UPTIME_HI.
  - Required: LO=0xFFFFFFFF and HI=0 (the shadow), not 1.
  - Build without the macro: 0x20 gives SLVERR.
- Hold rready low for 5 cycles after a read handshake, with a write to SCRATCH in the same cycle as the read of SCRATCH.
  - Required: rdata stable for all 5 cycles and equal to the old SCRATCH value.
  - Required: arready low until the read completes.
- Assert aresetn while rvalid=1 and bvalid=1.
  - Required: both drop immediately; SCRATCH reads 0 after release; no stray response appears.

Source files
------------

// File: rtl/identifier_pkg.sv
// identifier_pkg -- shared register map, response codes and feature bits for identifier_regs (rev 1.0)
`default_nettype none

package identifier_pkg;

  localparam int NAME_CHARS = 16;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int OFF_HASH      = 'h00;
  localparam int OFF_NAME0     = 'h04;
  localparam int OFF_VERSION   = 'h14;
  localparam int OFF_INFO      = 'h18;
  localparam int OFF_SCRATCH   = 'h1C;
  localparam int OFF_UPTIME_LO = 'h20;
  localparam int OFF_UPTIME_HI = 'h24;
  localparam int OFF_USER0     = 'h28;

  localparam int FEAT_UPTIME_BIT = 0;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } rd_result_t;

endpackage

`default_nettype wire

// File: rtl/identifier_uptime.sv
// identifier_uptime -- free-running 64-bit uptime counter with a high-word shadow for coherent reads (rev 1.0)
`default_nettype none

module identifier_uptime (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        latch_hi,
  output logic [31:0] lo,
  output logic [31:0] hi
);

  logic [63:0] count;
  logic [31:0] shadow;

  // The shadow captures the high word on the same edge the low word is read out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      shadow <= '0;
    end else begin
      count <= count + 64'd1;
      if (latch_hi) begin
        shadow <= count[63:32];
      end
    end
  end

  assign lo = count[31:0];
  assign hi = shadow;

endmodule

`default_nettype wire

// File: rtl/identifier_regs.sv
// identifier_regs -- AXI4-Lite identification/status registers; uptime counter built when IDENTIFIER_UPTIME_EN is defined (rev 1.0)
`default_nettype none

module identifier_regs
  import identifier_pkg::*;
#(
  parameter              NAME          = "TEST",
  parameter logic [31:0] HASH          = 32'h0,
  parameter logic [15:0] MAJOR_VERSION = 16'd1,
  parameter logic [15:0] MINOR_VERSION = 16'd0,
  parameter logic [15:0] PATCH_VERSION = 16'd0,
  parameter int          NUM_USER      = 0,
  parameter int          ADDR_WIDTH    = 8
) (
  input  logic                                     aclk,
  input  logic                                     aresetn,
  input  logic                                     ctrl_awvalid,
  output logic                                     ctrl_awready,
  input  logic [ADDR_WIDTH-1:0]                    ctrl_awaddr,
  input  logic                                     ctrl_wvalid,
  output logic                                     ctrl_wready,
  input  logic [31:0]                              ctrl_wdata,
  input  logic [3:0]                               ctrl_wstrb,
  output logic                                     ctrl_bvalid,
  input  logic                                     ctrl_bready,
  output logic [1:0]                               ctrl_bresp,
  input  logic                                     ctrl_arvalid,
  output logic                                     ctrl_arready,
  input  logic [ADDR_WIDTH-1:0]                    ctrl_araddr,
  output logic                                     ctrl_rvalid,
  input  logic                                     ctrl_rready,
  output logic [31:0]                              ctrl_rdata,
  output logic [1:0]                               ctrl_rresp,
  input  logic [((NUM_USER > 0) ? NUM_USER : 1)*32-1:0] user_info
);

  localparam int IW       = ADDR_WIDTH - 2;
  localparam int NAME_LEN = $bits(NAME) / 8;

`ifdef IDENTIFIER_UPTIME_EN
  localparam logic [7:0] FEATURES = 8'(1 << FEAT_UPTIME_BIT);
`else
  localparam logic [7:0] FEATURES = 8'h00;
`endif

  function automatic logic [IW-1:0] word_idx(input int off);
    return IW'(off / 4);
  endfunction

  // Character 0 of the name is the leftmost character of the string literal.
  logic [8*NAME_CHARS-1:0] name_flat;
  for (genvar i = 0; i < NAME_CHARS; i++) begin : g_name
    if (i < NAME_LEN) begin : g_char
      assign name_flat[8*i +: 8] = NAME[8*(NAME_LEN-1-i) +: 8];
    end else begin : g_pad
      assign name_flat[8*i +: 8] = 8'h20;
    end
  end

  logic [IW-1:0] rd_idx;
  logic [IW-1:0] wr_idx;
  logic          rd_fire;
  logic          wr_fire;
  logic          wr_is_scratch;
  logic [31:0]   scratch;
  rd_result_t    rd_next;

  assign rd_idx        = ctrl_araddr[ADDR_WIDTH-1:2];
  assign wr_idx        = ctrl_awaddr[ADDR_WIDTH-1:2];
  assign ctrl_arready  = !ctrl_rvalid;
  assign rd_fire       = ctrl_arvalid && ctrl_arready;
  assign ctrl_awready  = ctrl_awvalid && ctrl_wvalid && !ctrl_bvalid;
  assign ctrl_wready   = ctrl_awready;
  assign wr_fire       = ctrl_awready;
  assign wr_is_scratch = (wr_idx == word_idx(OFF_SCRATCH));

`ifdef IDENTIFIER_UPTIME_EN
  logic [31:0] up_lo;
  logic [31:0] up_hi;
  logic        latch_hi;

  assign latch_hi = rd_fire && (rd_idx == word_idx(OFF_UPTIME_LO));

  identifier_uptime u_uptime (
    .clk      (aclk),
    .rst_n    (aresetn),
    .latch_hi (latch_hi),
    .lo       (up_lo),
    .hi       (up_hi)
  );
`endif

  always_comb begin
    rd_next = '{data: 32'h0, resp: RESP_SLVERR};
    if (rd_idx == word_idx(OFF_HASH)) begin
      rd_next = '{data: HASH, resp: RESP_OKAY};
    end
    for (int j = 0; j < NAME_CHARS / 4; j++) begin
      if (rd_idx == word_idx(OFF_NAME0 + 4 * j)) begin
        rd_next = '{data: name_flat[32*j +: 32], resp: RESP_OKAY};
      end
    end
    if (rd_idx == word_idx(OFF_VERSION)) begin
      rd_next = '{data: {MAJOR_VERSION, MINOR_VERSION}, resp: RESP_OKAY};
    end
    if (rd_idx == word_idx(OFF_INFO)) begin
      rd_next = '{data: {PATCH_VERSION, 8'(NUM_USER), FEATURES}, resp: RESP_OKAY};
    end
    // Registered scratch value, so a same-cycle write is not visible to this read.
    if (rd_idx == word_idx(OFF_SCRATCH)) begin
      rd_next = '{data: scratch, resp: RESP_OKAY};
    end
`ifdef IDENTIFIER_UPTIME_EN
    if (rd_idx == word_idx(OFF_UPTIME_LO)) begin
      rd_next = '{data: up_lo, resp: RESP_OKAY};
    end
    if (rd_idx == word_idx(OFF_UPTIME_HI)) begin
      rd_next = '{data: up_hi, resp: RESP_OKAY};
    end
`endif
    for (int k = 0; k < NUM_USER; k++) begin
      if (rd_idx == word_idx(OFF_USER0 + 4 * k)) begin
        rd_next = '{data: user_info[32*k +: 32], resp: RESP_OKAY};
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ctrl_rvalid <= 1'b0;
      ctrl_rdata  <= 32'h0;
      ctrl_rresp  <= RESP_OKAY;
    end else if (rd_fire) begin
      ctrl_rvalid <= 1'b1;
      ctrl_rdata  <= rd_next.data;
      ctrl_rresp  <= rd_next.resp;
    end else if (ctrl_rvalid && ctrl_rready) begin
      ctrl_rvalid <= 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ctrl_bvalid <= 1'b0;
      ctrl_bresp  <= RESP_OKAY;
      scratch     <= 32'h0;
    end else if (wr_fire) begin
      ctrl_bvalid <= 1'b1;
      ctrl_bresp  <= wr_is_scratch ? RESP_OKAY : RESP_SLVERR;
      if (wr_is_scratch) begin
        for (int b = 0; b < 4; b++) begin
          if (ctrl_wstrb[b]) begin
            scratch[8*b +: 8] <= ctrl_wdata[8*b +: 8];
          end
        end
      end
    end else if (ctrl_bvalid && ctrl_bready) begin
      ctrl_bvalid <= 1'b0;
    end
  end

  // Byte-offset bits and surplus user words are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{ctrl_araddr[1:0], ctrl_awaddr[1:0], user_info};

endmodule

`default_nettype wire

// File: tb/tb_identifier_regs.sv
// tb_identifier_regs -- randomized self-checking bench for identifier_regs against a behavioural register model
`default_nettype none

module tb_identifier_regs;
  import identifier_pkg::*;

  localparam int          NUM_USER = 2;
  localparam int          AW       = 8;
  localparam logic [31:0] HASH_VAL = 32'hC0FFEE42;
  localparam string       NAME_STR = "TEST";
`ifdef IDENTIFIER_UPTIME_EN
  localparam bit UPT = 1'b1;
`else
  localparam bit UPT = 1'b0;
`endif

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic          awready, wready, bvalid, arready, rvalid;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic [31:0]   wdata = '0, rdata;
  logic [3:0]    wstrb = '0;
  logic [1:0]    bresp, rresp;
  logic [NUM_USER*32-1:0] user_info = '0;

  identifier_regs #(
    .NAME("TEST"), .HASH(HASH_VAL), .MAJOR_VERSION(16'd2), .MINOR_VERSION(16'd3),
    .PATCH_VERSION(16'd4), .NUM_USER(NUM_USER), .ADDR_WIDTH(AW)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .ctrl_awvalid(awvalid), .ctrl_awready(awready), .ctrl_awaddr(awaddr),
    .ctrl_wvalid(wvalid), .ctrl_wready(wready), .ctrl_wdata(wdata), .ctrl_wstrb(wstrb),
    .ctrl_bvalid(bvalid), .ctrl_bready(bready), .ctrl_bresp(bresp),
    .ctrl_arvalid(arvalid), .ctrl_arready(arready), .ctrl_araddr(araddr),
    .ctrl_rvalid(rvalid), .ctrl_rready(rready), .ctrl_rdata(rdata), .ctrl_rresp(rresp),
    .user_info(user_info)
  );

  always #5 aclk = ~aclk;

  int errors = 0;
  int checks = 0;

  // Model state
  logic [31:0]     m_scratch = '0;
  logic [31:0]     m_user [NUM_USER];
  longint unsigned m_edges;

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) m_edges <= 0;
    else          m_edges <= m_edges + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] name_char(input int i);
    string s;
    s = NAME_STR;
    if (i < s.len()) return s[i];
    return 8'h20;
  endfunction

  function automatic void model_read(input int addr, output logic [31:0] d, output logic [1:0] r);
    int w;
    w = addr / 4;
    d = 32'h0;
    r = 2'b00;
    if (w == 0)                          d = HASH_VAL;
    else if (w >= 1 && w <= 4)           for (int b = 0; b < 4; b++) d[8*b +: 8] = name_char(4*(w-1) + b);
    else if (w == 5)                     d = {16'd2, 16'd3};
    else if (w == 6)                     d = {16'd4, 8'(NUM_USER), 7'd0, UPT};
    else if (w == 7)                     d = m_scratch;
    else if (w >= 10 && w < 10+NUM_USER) d = m_user[w-10];
    else                                 r = 2'b10;
  endfunction

  function automatic logic [1:0] model_write(input int addr, input logic [31:0] d, input logic [3:0] s);
    if (addr / 4 != 7) return 2'b10;
    for (int b = 0; b < 4; b++) if (s[b]) m_scratch[8*b +: 8] = d[8*b +: 8];
    return 2'b00;
  endfunction

  task automatic do_read(input int addr, output logic [31:0] d, output logic [1:0] r,
                         output longint unsigned acc_edges);
    bit ok;
    int n;
    @(negedge aclk);
    araddr = AW'(addr); arvalid = 1'b1; rready = 1'b1;
    ok = 1'b0; n = 0; acc_edges = 0;
    while (!ok && n < 20) begin
      ok = arready; acc_edges = m_edges;
      @(posedge aclk); #1;
      n++;
    end
    arvalid = 1'b0;
    if (!ok) check("rd_accept_timeout", 0, 1);
    n = 0;
    while (!rvalid && n < 20) begin @(posedge aclk); #1; n++; end
    if (!rvalid) check("rd_resp_timeout", 0, 1);
    d = rdata; r = rresp;
    @(posedge aclk); #1;
  endtask

  task automatic do_write(input int addr, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] r);
    bit ok;
    int n;
    @(negedge aclk);
    awaddr = AW'(addr); wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    ok = 1'b0; n = 0;
    while (!ok && n < 20) begin
      ok = awready && wready;
      @(posedge aclk); #1;
      n++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (!ok) check("wr_accept_timeout", 0, 1);
    n = 0;
    while (!bvalid && n < 20) begin @(posedge aclk); #1; n++; end
    if (!bvalid) check("wr_resp_timeout", 0, 1);
    r = bresp;
    @(posedge aclk); #1;
  endtask

  task automatic drive_users();
    for (int i = 0; i < NUM_USER; i++) begin
      m_user[i] = $urandom;
      user_info[32*i +: 32] = m_user[i];
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, ed, old;
    logic [1:0]  r, er, br;
    longint unsigned e;
    int a;

    drive_users();
    repeat (3) @(posedge aclk);
    #1;
    check("rst_rvalid", rvalid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_rresp", rresp, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_bresp", bresp, 0);
    @(negedge aclk); aresetn = 1'b1;

    // Identification words
    for (int ad = 0; ad <= 'h18; ad += 4) begin
      do_read(ad, d, r, e);
      model_read(ad, ed, er);
      check($sformatf("id_%0h", ad), d, ed);
      check($sformatf("id_resp_%0h", ad), r, 2'b00);
    end
    do_read('h04, d, r, e);  check("name_w0", d, 32'h54534554);
    do_read('h10, d, r, e);  check("name_w3", d, 32'h20202020);
    do_read('h14, d, r, e);  check("version", d, 32'h00020003);

    // Scratch byte strobes
    do_write('h1C, 32'hDEADBEEF, 4'hF, br); check("scr_bresp1", br, model_write('h1C, 32'hDEADBEEF, 4'hF));
    do_write('h1C, 32'h00000011, 4'h1, br); check("scr_bresp2", br, model_write('h1C, 32'h00000011, 4'h1));
    do_read('h1C, d, r, e); check("scr_strb", d, 32'hDEADBE11);

    // Illegal write, unmapped read
    do_write('h00, 32'h12345678, 4'hF, br); check("ro_bresp", br, 2'b10);
    do_read('h00, d, r, e);  check("hash_kept", d, HASH_VAL);
    do_read('h7C, d, r, e);  check("unmap_data", d, 0); check("unmap_resp", r, 2'b10);

`ifdef IDENTIFIER_UPTIME_EN
    do_read('h20, d, r, e);  check("up_lo", d, e[31:0]); check("up_lo_resp", r, 2'b00);
    do_read('h24, d, r, e);  check("up_hi", d, 0);
    @(negedge aclk);
    force dut.u_uptime.count = 64'h0000_0000_FFFF_FFFF;
    araddr = AW'('h20); arvalid = 1'b1; rready = 1'b1;
    @(posedge aclk); #1;
    release dut.u_uptime.count;
    arvalid = 1'b0;
    check("wrap_lo", rdata, 32'hFFFFFFFF);
    @(posedge aclk); #1;
    do_read('h24, d, r, e);  check("wrap_hi_shadow", d, 0); check("wrap_hi_resp", r, 2'b00);
`else
    do_read('h20, d, r, e);  check("noup_lo", d, 0); check("noup_lo_resp", r, 2'b10);
    do_read('h24, d, r, e);  check("noup_hi_resp", r, 2'b10);
`endif

    // AW without W must wait
    @(negedge aclk);
    awaddr = AW'('h1C); wdata = 32'h0BAD0BAD; wstrb = 4'hF; awvalid = 1'b1; bready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1; check("aw_only_ready", {awready, wready}, 2'b00);
      @(posedge aclk); #1; check("aw_only_bvalid", bvalid, 0);
      @(negedge aclk);
    end
    awvalid = 1'b0;

    // Simultaneous read and write of scratch with a stalled read
    old = m_scratch;
    @(negedge aclk);
    araddr = AW'('h1C); arvalid = 1'b1; rready = 1'b0;
    awaddr = AW'('h1C); wdata = 32'h12345678; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(posedge aclk); #1;
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    check("sim_bvalid", bvalid, 1);
    check("sim_bresp", bresp, model_write('h1C, 32'h12345678, 4'hF));
    bready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("stall_rvalid", rvalid, 1);
      check("stall_rdata", rdata, old);
      check("stall_arready", arready, 0);
      @(posedge aclk); #1;
    end
    @(negedge aclk); rready = 1'b1;
    @(posedge aclk); #1;
    check("stall_done_rvalid", rvalid, 0);
    check("stall_done_arready", arready, 1);
    do_read('h1C, d, r, e); check("scr_new", d, m_scratch);

    // Randomized traffic against the model
    for (int it = 0; it < 60; it++) begin
      drive_users();
      if ($urandom_range(0, 1) == 0) begin
        a = $urandom_range(0, 'h4F);
        if (a / 4 == 8 || a / 4 == 9) a = 'h1C;
        model_read(a, ed, er);
        do_read(a, d, r, e);
        check($sformatf("rnd_rd_%0h", a), d, ed);
        check($sformatf("rnd_rresp_%0h", a), r, er);
      end else begin
        a = ($urandom_range(0, 1) == 0) ? ('h1C | $urandom_range(0, 3)) : $urandom_range(0, 'h4F);
        d = $urandom;
        wstrb = 4'($urandom);
        er = model_write(a, d, wstrb);
        do_write(a, d, wstrb, br);
        check($sformatf("rnd_bresp_%0h", a), br, er);
      end
    end

    // Reset while both responses are pending
    @(negedge aclk);
    araddr = AW'('h00); arvalid = 1'b1; rready = 1'b0;
    awaddr = AW'('h1C); wdata = 32'hA5A5A5A5; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(posedge aclk); #1;
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    check("pre_rst_valids", {rvalid, bvalid}, 2'b11);
    #2 aresetn = 1'b0;
    #1 check("async_rst_valids", {rvalid, bvalid}, 2'b00);
    m_scratch = 32'h0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1; rready = 1'b1; bready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge aclk); #1;
      check("no_stray_resp", {rvalid, bvalid}, 2'b00);
    end
    do_read('h1C, d, r, e); check("scr_after_rst", d, m_scratch);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
